dynamic_output_rr_para: RTL and testbench
=========================================

Name: dynamic_output_rr_para

Overview:
- Parametrised next-generation output port for the dynamic network router.
- Arbitrates NUM_IN input channels onto one output link using round-robin, with wormhole locking held until the tail flit.
- Tracks downstream buffer space with an internal credit counter replenished by yummy_in.
- Drives a registered output stage, optionally drops header flits, and flags popped zero-length interrupt headers.

Parameters:
NUM_IN, 5, number of input channels (2..8)
DATA_WIDTH, 64, flit width
CREDITS, 4, downstream buffer depth = initial credit count (1..15)
KILL_HEADERS, 0, 1 = header flits consumed but not forwarded
LEN_LSB, 22, LSB of payload-length field in header
LEN_WIDTH, 8, payload-length field width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
route_req_in  in  NUM_IN  per-channel request; high with a header flit targeting this port
tail_in  in  NUM_IN  per-channel; current flit is the packet tail
valid_in  in  NUM_IN  per-channel flit valid
data_in  in  NUM_IN*DATA_WIDTH  channel i occupies [i*DATA_WIDTH +: DATA_WIDTH]
yummy_in  in  1  downstream freed one buffer slot
thanks_out  out  NUM_IN  one-hot; flit of channel i consumed this cycle
data_out  out  DATA_WIDTH  registered output flit
valid_out  out  1  registered output valid
credit_cnt_out  out  4  current credit count
popped_interrupt_out  out  1  registered pulse; killed header had len==0 and data[23:20]==4'hF
credit_err_out  out  1  sticky; yummy received while credits==CREDITS
ec_wants_to_send_but_cannot  out  1  flit pending but credits==0

Behaviour:
- Reset (rst_n low, async): state IDLE, rr_ptr=0, credits=CREDITS, valid_out=0, data_out=0, thanks_out=0, popped_interrupt_out=0, credit_err_out=0.
- Reset mid-packet discards the lock; no flit is emitted after reset release until a new header wins.
- can_send = (credits != 0).
- State machine, IDLE:
  - Candidates are route_req_in & valid_in.
  - Winner w is the first candidate at or after rr_ptr, searching cyclically.
  - If any candidate and can_send: thanks_out[w]=1 and the header is consumed that cycle (zero arbitration latency).
  - If tail_in[w] is also high (single-flit packet): stay IDLE, rr_ptr=(w+1) mod NUM_IN.
  - Otherwise: go to BUSY, cur=w.
- State machine, BUSY:
  - thanks_out[cur] = valid_in[cur] & can_send.
  - On a consumed flit with tail_in[cur]=1: go to IDLE, rr_ptr=(cur+1) mod NUM_IN.
  - Requests from other channels are ignored while BUSY.
- Output stage:
  - On a consumed flit, next cycle data_out=flit and valid_out=1.
  - Otherwise valid_out=0 and data_out holds its previous value.
  - Latency is 1 cycle from thanks to valid_out.
- KILL_HEADERS=1:
  - A header consumed in IDLE is not forwarded (valid_out=0 next cycle) and consumes no credit.
  - The header still needs can_send to win.
  - popped_interrupt_out pulses 1 cycle after a killed header with data[LEN_LSB+:LEN_WIDTH]==0 and data[23:20]==4'hF.
- Credits:
  - Decrement on each forwarded flit (at thanks time); increment on yummy_in.
  - Both in the same cycle: count unchanged.
  - yummy_in at count==CREDITS: count stays CREDITS, credit_err_out set until reset.
  - Count never underflows; sends are blocked at 0.
- ec_wants_to_send_but_cannot is combinational: (IDLE & |(route_req_in&valid_in) | BUSY & valid_in[cur]) & credits==0.
- thanks_out is always one-hot or zero.

Test Plan:
- Reset, CREDITS=4; ch0 sends 3-flit packet (tail on 3rd), no yummy → thanks_out=5'b00001 for 3 cycles, valid_out high cycles 2–4, credit_cnt_out 4→1.
- Ch1 and ch3 request simultaneously with rr_ptr=0, single-flit packets → ch1 wins first, ch3 next cycle; with ch1 requesting again, ch3 then ch1 alternate.
- Credits at 0 with ch2 valid in BUSY → thanks_out=0, ec_wants_to_send_but_cannot=1; yummy_in 1 cycle → next cycle thanks_out[2]=1, count returns to 0.
- Send and yummy in the same cycle at count=2 → count stays 2; yummy at count=4 → count 4, credit_err_out=1 and sticky.
- KILL_HEADERS=1, header len=0 with data[23:20]=4'hF on ch0 → thanks_out[0]=1, valid_out stays 0, popped_interrupt_out=1 next cycle, credits unchanged.
- rst_n low mid-packet (BUSY, ch4) → immediately valid_out=0, credits=CREDITS; after release ch4 body flits without route_req get no thanks.

Source files
------------

// File: rtl/dynamic_output_rr_para.sv
// dynamic_output_rr_para: round-robin output port with wormhole locking,
// credit-based flow control, registered output stage and optional header kill.
module dynamic_output_rr_para #(
    parameter int unsigned NUM_IN       = 5,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned CREDITS      = 4,
    parameter int unsigned KILL_HEADERS = 0,
    parameter int unsigned LEN_LSB      = 22,
    parameter int unsigned LEN_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            route_req_in,
    input  logic [NUM_IN-1:0]            tail_in,
    input  logic [NUM_IN-1:0]            valid_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    input  logic                         yummy_in,
    output logic [NUM_IN-1:0]            thanks_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic [3:0]                   credit_cnt_out,
    output logic                         popped_interrupt_out,
    output logic                         credit_err_out,
    output logic                         ec_wants_to_send_but_cannot
);

    localparam int unsigned PTR_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [3:0]  CRED_MAX = 4'(CREDITS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   cur_q, cur_d;
    logic [3:0]         credits_q, credits_d;
    logic               err_q;
    logic [NUM_IN-1:0]  cand;
    logic [NUM_IN-1:0]  thanks;
    logic               any_cand;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   sel;
    logic               can_send;
    logic               consume;
    logic               kill;
    logic               forward;
    logic               interrupt_hdr;
    logic [DATA_WIDTH-1:0] flit;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_IN - 1) ? '0 : p + 1'b1;
    endfunction

    assign cand     = route_req_in & valid_in;
    assign can_send = (credits_q != 4'd0);

    // Cyclic search for the first requesting channel at or after rr_ptr
    always_comb begin
        int unsigned idx;
        idx      = 0;
        winner   = rr_ptr_q;
        any_cand = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_IN;
            if (!any_cand && cand[PTR_W'(idx)]) begin
                any_cand = 1'b1;
                winner   = PTR_W'(idx);
            end
        end
    end

    // Arbitration / wormhole FSM next-state and thanks generation
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        thanks   = '0;
        sel      = cur_q;
        kill     = 1'b0;
        case (state_q)
            IDLE: begin
                sel = winner;
                if (any_cand && can_send) begin
                    thanks[winner] = 1'b1;
                    kill           = (KILL_HEADERS != 0);
                    if (tail_in[winner]) begin
                        rr_ptr_d = next_ptr(winner);
                    end else begin
                        state_d = BUSY;
                        cur_d   = winner;
                    end
                end
            end
            BUSY: begin
                if (valid_in[cur_q] && can_send) begin
                    thanks[cur_q] = 1'b1;
                    if (tail_in[cur_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr(cur_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Nothing is consumed while reset is held
        if (!rst_n) begin
            thanks = '0;
        end
    end

    assign consume       = |thanks;
    assign forward       = consume && !kill;
    assign flit          = data_in[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign interrupt_hdr = (flit[LEN_LSB +: LEN_WIDTH] == '0) && (flit[23:20] == 4'hF);

    // Credit counter next value: send and yummy together cancel out
    always_comb begin
        credits_d = credits_q;
        if (forward && !yummy_in) begin
            credits_d = credits_q - 4'd1;
        end else if (yummy_in && !forward && credits_q != CRED_MAX) begin
            credits_d = credits_q + 4'd1;
        end
    end

    // FSM, pointer and credit state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_q     <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_q     <= cur_d;
            credits_q <= credits_d;
            if (yummy_in && credits_q == CRED_MAX) begin
                err_q <= 1'b1;
            end
        end
    end

    // Registered output stage and interrupt pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out             <= '0;
            valid_out            <= 1'b0;
            popped_interrupt_out <= 1'b0;
        end else begin
            valid_out            <= forward;
            popped_interrupt_out <= consume && kill && interrupt_hdr;
            if (forward) begin
                data_out <= flit;
            end
        end
    end

    assign thanks_out     = thanks;
    assign credit_cnt_out = credits_q;
    assign credit_err_out = err_q;
    assign ec_wants_to_send_but_cannot =
        ((state_q == IDLE && any_cand) || (state_q == BUSY && valid_in[cur_q]))
        && (credits_q == 4'd0);

endmodule

// File: tb/tb_dynamic_output_rr_para.sv
// Directed bench for dynamic_output_rr_para: a forwarding instance (a) and
// a header-killing instance (b).
module tb_dynamic_output_rr_para;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 64;

    logic clk;
    logic rst_n;

    logic [N-1:0]    req_a, tail_a, valid_a, thanks_a;
    logic [N*DW-1:0] data_a;
    logic            yummy_a;
    logic [DW-1:0]   dout_a;
    logic            vout_a, pop_a, err_a, ec_a;
    logic [3:0]      cred_a;

    logic [N-1:0]    req_b, tail_b, valid_b, thanks_b;
    logic [N*DW-1:0] data_b;
    logic            yummy_b;
    logic [DW-1:0]   dout_b;
    logic            vout_b, pop_b, err_b, ec_b;
    logic [3:0]      cred_b;

    int checks = 0;
    int errors = 0;

    dynamic_output_rr_para #(
        .NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(4), .KILL_HEADERS(0),
        .LEN_LSB(22), .LEN_WIDTH(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .route_req_in(req_a), .tail_in(tail_a), .valid_in(valid_a),
        .data_in(data_a), .yummy_in(yummy_a), .thanks_out(thanks_a),
        .data_out(dout_a), .valid_out(vout_a), .credit_cnt_out(cred_a),
        .popped_interrupt_out(pop_a), .credit_err_out(err_a),
        .ec_wants_to_send_but_cannot(ec_a)
    );

    // Length field placed at bit 30 so it does not overlap bits 23:20
    dynamic_output_rr_para #(
        .NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(4), .KILL_HEADERS(1),
        .LEN_LSB(30), .LEN_WIDTH(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .route_req_in(req_b), .tail_in(tail_b), .valid_in(valid_b),
        .data_in(data_b), .yummy_in(yummy_b), .thanks_out(thanks_b),
        .data_out(dout_b), .valid_out(vout_b), .credit_cnt_out(cred_b),
        .popped_interrupt_out(pop_b), .credit_err_out(err_b),
        .ec_wants_to_send_but_cannot(ec_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_a = '0; tail_a = '0; valid_a = '0; data_a = '0; yummy_a = 1'b0;
        req_b = '0; tail_b = '0; valid_b = '0; data_b = '0; yummy_b = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        // reset state
        chk("rst_vout", 64'(vout_a), 64'd0);
        chk("rst_dout", dout_a, 64'd0);
        chk("rst_cred", 64'(cred_a), 64'd4);
        chk("rst_thanks", 64'(thanks_a), 64'd0);
        chk("rst_pop", 64'(pop_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        rst_n = 1'b1;
        tick();

        // 3-flit packet on ch0, zero arbitration latency
        req_a = 5'b00001; valid_a = 5'b00001; data_a[0 +: 64] = 64'hA1;
        #1;
        chk("p3_thanks1", 64'(thanks_a), 64'h01);
        chk("p3_ec1", 64'(ec_a), 64'd0);
        tick();
        chk("p3_vout1", 64'(vout_a), 64'd1);
        chk("p3_dout1", dout_a, 64'hA1);
        chk("p3_cred1", 64'(cred_a), 64'd3);
        req_a = '0; data_a[0 +: 64] = 64'hA2;
        #1;
        chk("p3_thanks2", 64'(thanks_a), 64'h01);
        tick();
        chk("p3_dout2", dout_a, 64'hA2);
        chk("p3_cred2", 64'(cred_a), 64'd2);
        tail_a = 5'b00001; data_a[0 +: 64] = 64'hA3;
        #1;
        chk("p3_thanks3", 64'(thanks_a), 64'h01);
        tick();
        chk("p3_dout3", dout_a, 64'hA3);
        chk("p3_cred3", 64'(cred_a), 64'd1);
        clear_inputs();
        #1;
        chk("p3_thanks_idle", 64'(thanks_a), 64'd0);
        tick();
        chk("p3_vout_off", 64'(vout_a), 64'd0);
        chk("p3_dout_hold", dout_a, 64'hA3);
        yummy_a = 1'b1;
        tick(); tick(); tick();
        yummy_a = 1'b0;
        chk("p3_cred_refill", 64'(cred_a), 64'd4);
        chk("p3_err_clean", 64'(err_a), 64'd0);

        // round robin ch1/ch3 single-flit packets from rr_ptr=0
        do_reset();
        req_a = 5'b01010; valid_a = 5'b01010; tail_a = 5'b01010;
        data_a[64 +: 64] = 64'hB1; data_a[192 +: 64] = 64'hB3;
        #1;
        chk("rr_w1", 64'(thanks_a), 64'h02);
        tick();
        chk("rr_d1", dout_a, 64'hB1);
        chk("rr_c1", 64'(cred_a), 64'd3);
        #1;
        chk("rr_w2", 64'(thanks_a), 64'h08);
        tick();
        chk("rr_d2", dout_a, 64'hB3);
        chk("rr_c2", 64'(cred_a), 64'd2);
        #1;
        chk("rr_w3", 64'(thanks_a), 64'h02);
        tick();
        chk("rr_c3", 64'(cred_a), 64'd1);
        #1;
        chk("rr_w4", 64'(thanks_a), 64'h08);
        tick();
        chk("rr_c4", 64'(cred_a), 64'd0);
        chk("rr_v4", 64'(vout_a), 64'd1);
        #1;
        chk("rr_blocked_thanks", 64'(thanks_a), 64'd0);
        chk("rr_blocked_ec", 64'(ec_a), 64'd1);
        tick();
        chk("rr_blocked_vout", 64'(vout_a), 64'd0);
        chk("rr_blocked_cred", 64'(cred_a), 64'd0);
        clear_inputs();

        // ch2 stalls in BUSY at zero credits, one yummy releases one flit
        yummy_a = 1'b1;
        tick();
        yummy_a = 1'b0;
        chk("cz_cred1", 64'(cred_a), 64'd1);
        req_a = 5'b00100; valid_a = 5'b00100; data_a[128 +: 64] = 64'hC0;
        #1;
        chk("cz_hdr_thanks", 64'(thanks_a), 64'h04);
        tick();
        chk("cz_cred0", 64'(cred_a), 64'd0);
        chk("cz_dout0", dout_a, 64'hC0);
        req_a = '0; data_a[128 +: 64] = 64'hC1;
        #1;
        chk("cz_stall_thanks", 64'(thanks_a), 64'd0);
        chk("cz_stall_ec", 64'(ec_a), 64'd1);
        tick();
        chk("cz_stall_vout", 64'(vout_a), 64'd0);
        yummy_a = 1'b1;
        #1;
        chk("cz_yummy_thanks", 64'(thanks_a), 64'd0);
        tick();
        yummy_a = 1'b0;
        chk("cz_cred_back", 64'(cred_a), 64'd1);
        tail_a = 5'b00100;
        #1;
        chk("cz_rel_thanks", 64'(thanks_a), 64'h04);
        chk("cz_rel_ec", 64'(ec_a), 64'd0);
        tick();
        chk("cz_rel_cred", 64'(cred_a), 64'd0);
        chk("cz_rel_vout", 64'(vout_a), 64'd1);
        chk("cz_rel_dout", dout_a, 64'hC1);
        clear_inputs();

        // simultaneous send+yummy, then overflow yummy
        yummy_a = 1'b1;
        tick(); tick();
        chk("sy_cred2", 64'(cred_a), 64'd2);
        req_a = 5'b00001; valid_a = 5'b00001; tail_a = 5'b00001;
        data_a[0 +: 64] = 64'hD0;
        #1;
        chk("sy_thanks", 64'(thanks_a), 64'h01);
        tick();
        chk("sy_cred_same", 64'(cred_a), 64'd2);
        chk("sy_dout", dout_a, 64'hD0);
        clear_inputs();
        yummy_a = 1'b1;
        tick(); tick();
        chk("sy_cred4", 64'(cred_a), 64'd4);
        chk("sy_err_pre", 64'(err_a), 64'd0);
        tick();
        yummy_a = 1'b0;
        chk("ov_cred", 64'(cred_a), 64'd4);
        chk("ov_err", 64'(err_a), 64'd1);
        tick();
        chk("ov_err_sticky", 64'(err_a), 64'd1);
        req_a = 5'b00010; valid_a = 5'b00010; tail_a = 5'b00010;
        data_a[64 +: 64] = 64'hD1;
        #1;
        chk("ov_send_thanks", 64'(thanks_a), 64'h02);
        tick();
        chk("ov_send_cred", 64'(cred_a), 64'd3);
        chk("ov_err_sticky2", 64'(err_a), 64'd1);
        clear_inputs();

        // reset while ch4 holds the output
        req_a = 5'b10000; valid_a = 5'b10000; data_a[256 +: 64] = 64'hE0;
        #1;
        chk("mr_hdr_thanks", 64'(thanks_a), 64'h10);
        tick();
        chk("mr_cred2", 64'(cred_a), 64'd2);
        req_a = '0; data_a[256 +: 64] = 64'hE1;
        #1;
        chk("mr_body_thanks", 64'(thanks_a), 64'h10);
        tick();
        chk("mr_dout", dout_a, 64'hE1);
        chk("mr_cred1", 64'(cred_a), 64'd1);
        data_a[256 +: 64] = 64'hE2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rst_vout", 64'(vout_a), 64'd0);
        chk("mr_rst_cred", 64'(cred_a), 64'd4);
        chk("mr_rst_thanks", 64'(thanks_a), 64'd0);
        chk("mr_rst_err", 64'(err_a), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_post_thanks", 64'(thanks_a), 64'd0);
        tick();
        chk("mr_post_vout", 64'(vout_a), 64'd0);
        tail_a = 5'b10000;
        #1;
        chk("mr_tail_thanks", 64'(thanks_a), 64'd0);
        tick();
        chk("mr_tail_vout", 64'(vout_a), 64'd0);
        chk("mr_tail_cred", 64'(cred_a), 64'd4);

        // header kill on instance b
        do_reset();
        req_b = 5'b00001; valid_b = 5'b00001; tail_b = 5'b00001;
        data_b[0 +: 64] = 64'h0000_0000_00F0_0000;
        #1;
        chk("kh_thanks", 64'(thanks_b), 64'h01);
        tick();
        chk("kh_vout", 64'(vout_b), 64'd0);
        chk("kh_pop", 64'(pop_b), 64'd1);
        chk("kh_cred", 64'(cred_b), 64'd4);
        chk("kh_dout", dout_b, 64'd0);
        clear_inputs();
        tick();
        chk("kh_pop_pulse", 64'(pop_b), 64'd0);
        req_b = 5'b00001; valid_b = 5'b00001;
        data_b[0 +: 64] = 64'h0000_0001_40F0_0000;
        #1;
        chk("kh2_thanks", 64'(thanks_b), 64'h01);
        tick();
        chk("kh2_vout", 64'(vout_b), 64'd0);
        chk("kh2_pop", 64'(pop_b), 64'd0);
        chk("kh2_cred", 64'(cred_b), 64'd4);
        req_b = '0; tail_b = 5'b00001; data_b[0 +: 64] = 64'hD00D;
        #1;
        chk("kh2_body_thanks", 64'(thanks_b), 64'h01);
        tick();
        chk("kh2_body_vout", 64'(vout_b), 64'd1);
        chk("kh2_body_dout", dout_b, 64'hD00D);
        chk("kh2_body_cred", 64'(cred_b), 64'd3);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
